ecc_dec: RTL

Pipelined 64-bit SECDED decoder/corrector that sits directly downstream of the ECC encoder and the storage it protects. It consumes the 64-bit data word and the 8-bit check byte produced by the encoder, then recomputes the syndrome. It corrects any single-bit error, flags double-bit errors, and keeps saturating error statistics plus a first-uncorrectable log for software. Valid/ready handshakes on both sides allow it to sit between a memory read path and a consumer that can stall.

---
 rtl/ecc_pkg.sv | 36 +++
 rtl/ecc_syndrome.sv | 22 ++
 rtl/ecc_dec.sv | 119 +++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared SECDED code definitions for the 64-bit ECC encoder and decoder.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package ecc_pkg;

    localparam int DATA_WIDTH   = 64;
    localparam int ECC_WIDTH    = 8;
    localparam int PARITY_WIDTH = 7;
    localparam int CODE_WIDTH   = 72;

    // Hamming position of data bit idx; each range skips the check-bit
    // slots (powers of two) that precede it.
    function automatic logic [6:0] data_pos(input int idx);
        int p;
        if (idx < 1)       p = idx + 3;
        else if (idx < 4)  p = idx + 4;
        else if (idx < 11) p = idx + 5;
        else if (idx < 26) p = idx + 6;
        else if (idx < 57) p = idx + 7;
        else               p = idx + 8;
        return p[6:0];
    endfunction

    // Data bits whose Hamming position has bit i set, i.e. the bits covered by p_i.
    function automatic logic [DATA_WIDTH-1:0] cov_mask(input int i);
        logic [DATA_WIDTH-1:0] m;
        logic [6:0]            pos;
        m = '0;
        for (int d = 0; d < DATA_WIDTH; d++) begin
            pos  = data_pos(d);
            m[d] = pos[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational Hamming syndrome and overall parity over a 64+8 bit codeword.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no state.
module ecc_syndrome
    import ecc_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [ECC_WIDTH-1:0]    ecc,
    output logic [PARITY_WIDTH-1:0] s,
    output logic                    ov
);

    // Each syndrome bit re-derives p_i from the data and compares it to the received one.
    always_comb begin
        s = '0;
        for (int i = 0; i < PARITY_WIDTH; i++) begin
            s[i] = ecc[i] ^ (^(data & cov_mask(i)));
        end
        ov = (^data) ^ (^ecc);
    end

endmodule

// File: rtl/ecc_dec.sv
// Two-stage SECDED decoder: syndrome, single-bit correction, double-bit detect, stats.
// Latency: 2 cycles from input handshake to out_valid; 1 word/cycle throughput.
// Backpressure: both stages advance only when the output slot is empty or consumed.
module ecc_dec
    import ecc_pkg::*;
#(
    parameter int CNT_WIDTH = 16
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ECC_WIDTH-1:0]  in_ecc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ce,
    output logic                  out_ue,
    output logic [7:0]            out_syndrome,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  cnt_ce,
    output logic [CNT_WIDTH-1:0]  cnt_ue,
    output logic                  ue_log_valid,
    output logic [7:0]            ue_log_syndrome
);

    logic                    adv;
    logic                    hs;
    logic [PARITY_WIDTH-1:0] s_raw;
    logic                    ov_raw;

    logic                    s1_vld;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic [PARITY_WIDTH-1:0] s1_s;
    logic                    s1_ov;

    logic [DATA_WIDTH-1:0]   flip;
    logic                    ce_c;
    logic                    ue_c;

    ecc_syndrome u_syn (
        .data (in_data),
        .ecc  (in_ecc),
        .s    (s_raw),
        .ov   (ov_raw)
    );

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv && !rst;
    assign hs       = out_valid && out_ready;

    // Stage 1: capture raw data with its syndrome; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_s    <= '0;
            s1_ov   <= 1'b0;
        end else if (adv) begin
            s1_vld  <= in_valid;
            s1_data <= in_data;
            s1_s    <= s_raw;
            s1_ov   <= ov_raw;
        end
    end

    // Classify: with odd overall parity every syndrome below 72 is a single error
    // (0 = overall bit, power of two = check bit, otherwise a data position).
    always_comb begin
        flip = '0;
        for (int d = 0; d < DATA_WIDTH; d++) begin
            flip[d] = s1_ov && (s1_s == data_pos(d));
        end
        ce_c = s1_ov && (s1_s < 7'd72);
        ue_c = (s1_ov && (s1_s >= 7'd72)) || (!s1_ov && (s1_s != '0));
    end

    // Stage 2: register corrected word and flags; held stable during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ce       <= 1'b0;
            out_ue       <= 1'b0;
            out_syndrome <= '0;
        end else if (adv) begin
            out_valid    <= s1_vld;
            out_data     <= s1_data ^ flip;
            out_ce       <= s1_vld && ce_c;
            out_ue       <= s1_vld && ue_c;
            out_syndrome <= {s1_ov, s1_s};
        end
    end

    // Saturating error counters, counted on the output handshake; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_ce <= '0;
            cnt_ue <= '0;
        end else if (hs) begin
            if (out_ce && (cnt_ce != {CNT_WIDTH{1'b1}})) cnt_ce <= cnt_ce + 1'b1;
            if (out_ue && (cnt_ue != {CNT_WIDTH{1'b1}})) cnt_ue <= cnt_ue + 1'b1;
        end
    end

    // First-uncorrectable log: sticky until cleared, never overwritten by later UEs.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            ue_log_valid    <= 1'b0;
            ue_log_syndrome <= '0;
        end else if (hs && out_ue && !ue_log_valid) begin
            ue_log_valid    <= 1'b1;
            ue_log_syndrome <= out_syndrome;
        end
    end

endmodule
